// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: byte-oriented command responder sitting between a UART
// and a small register bus. 'R' addr reads a register, 'W' addr data writes
// one. Every command gets exactly one response byte: data, ACK or NAK.
// Handshakes: RX_VALID is a one-cycle strobe with no back-pressure, so bytes
// arriving while a command is executing or responding are dropped. TX_WE is
// raised for one cycle, the cycle after SEND observes TX_READY high. REG_WE is
// a one-cycle strobe with REG_ADDR/REG_WDATA stable in the same cycle.
module uart_cmd_responder #(
  parameter int NUM_REGS = 16,
  parameter int TIMEOUT  = 50000
) (
  input  logic       CLK_25MHz,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic [7:0] TX_DATA,
  output logic       TX_WE,
  input  logic       TX_READY,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY,
  output logic [7:0] ERR_COUNT,
  output logic [2:0] DBG_STATE
);

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  localparam int         TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    EXEC     = 3'd3,
    SEND     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic          addr_ok_q, addr_ok_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_we_q, tx_we_d;
  logic [7:0]    err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_inc;
  logic          reg_we_c;

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge CLK_25MHz) begin
    if (RST) begin
      state_q     <= IDLE;
      cmd_wr_q    <= 1'b0;
      addr_ok_q   <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_we_q     <= 1'b0;
      err_q       <= 8'h00;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      addr_ok_q   <= addr_ok_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      tx_data_q   <= tx_data_d;
      tx_we_q     <= tx_we_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state, register-bus strobe and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    addr_ok_d   = addr_ok_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_data_d   = tx_data_q;
    tx_we_d     = 1'b0;
    tmo_d       = tmo_q;
    err_inc     = 1'b0;
    reg_we_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // Holding the counter at zero here makes entry to GET_ADDR start clean.
        tmo_d = '0;
        if (RX_VALID) begin
          if (RX_DATA == CMD_READ || RX_DATA == CMD_WRITE) begin
            cmd_wr_d = (RX_DATA == CMD_WRITE);
            state_d  = GET_ADDR;
          end else begin
            tx_data_d = RSP_NAK;
            err_inc   = 1'b1;
            state_d   = SEND;
          end
        end
      end
      GET_ADDR: begin
        // An arriving byte wins over a timeout expiring in the same cycle.
        if (RX_VALID) begin
          tmo_d      = '0;
          reg_addr_d = RX_DATA;
          addr_ok_d  = ({1'b0, RX_DATA} < NUM_REGS_W);
          state_d    = cmd_wr_q ? GET_DATA : EXEC;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GET_DATA: begin
        if (RX_VALID) begin
          tmo_d       = '0;
          reg_wdata_d = RX_DATA;
          state_d     = EXEC;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      EXEC: begin
        if (!addr_ok_q) begin
          tx_data_d = RSP_NAK;
          err_inc   = 1'b1;
        end else if (cmd_wr_q) begin
          reg_we_c  = 1'b1;
          tx_data_d = RSP_ACK;
        end else begin
          tx_data_d = REG_RDATA;
        end
        state_d = SEND;
      end
      SEND: begin
        if (TX_READY) begin
          tx_we_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  assign TX_DATA   = tx_data_q;
  assign TX_WE     = tx_we_q;
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign REG_WE    = reg_we_c;
  assign BUSY      = (state_q != IDLE);
  assign ERR_COUNT = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter NUM_REGS, default 16: number of addressable registers, legal range 1..256.
REQ-002 Parameter TIMEOUT, default 50000: maximum clock cycles allowed between command bytes (2 ms at 25 MHz).
REQ-003 CLK_25MHz  input  1  sole clock; all logic on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 RX_DATA  input  8  received byte from the UART.
REQ-006 RX_VALID  input  1  one-cycle strobe; RX_DATA is valid in that cycle.
REQ-007 TX_DATA  output  8  response byte to the UART; registered.
REQ-008 TX_WE  output  1  one-cycle transmit strobe; registered.
REQ-009 TX_READY  input  1  UART can accept a byte.
REQ-010 REG_ADDR  output  8  register bus address; registered.
REQ-011 REG_WDATA  output  8  register bus write data; registered.
REQ-012 REG_WE  output  1  one-cycle register write strobe.
REQ-013 REG_RDATA  input  8  read data for REG_ADDR; combinational, valid in the same cycle.
REQ-014 BUSY  output  1  high whenever state is not IDLE.
REQ-015 ERR_COUNT  output  8  saturating count of NAKs plus timeouts.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND.
REQ-017 Protocol:
- read = 0x52 ('R'), addr -> one response byte = register data
- write = 0x57 ('W'), addr, data -> response 0x06 (ACK)
- any failure -> response 0x15 (NAK)
REQ-018 IDLE, RX_VALID with 0x52 or 0x57: latch the command, go to GET_ADDR.
REQ-019 IDLE, RX_VALID with any other byte: TX_DATA = 0x15, go to SEND, increment ERR_COUNT.
REQ-020 GET_ADDR, RX_VALID:
- latch the byte into REG_ADDR and record whether addr < NUM_REGS
- read command -> EXEC
- write command -> GET_DATA, including when addr is out of range
REQ-021 GET_DATA, RX_VALID: latch the byte into REG_WDATA, go to EXEC.
REQ-022 EXEC lasts exactly one cycle and then goes to SEND:
- read, in range: TX_DATA = REG_RDATA sampled in this cycle
- write, in range: REG_WE = 1 for this cycle only; TX_DATA = 0x06
- out of range: TX_DATA = 0x15; ERR_COUNT increments; REG_WE stays 0
REQ-023 SEND:
- while TX_READY = 0, hold state and TX_DATA
- first cycle TX_READY = 1: TX_WE = 1 for one cycle, then go to IDLE
- TX_WE is never asserted while TX_READY = 0
REQ-024 Latency, TX_READY held high:
- read: addr RX_VALID in cycle t -> EXEC in t+1 -> TX_WE in t+3
- write: data RX_VALID in cycle t -> REG_WE in t+1 -> TX_WE in t+3
- bad command: RX_VALID in cycle t -> TX_WE in t+2
REQ-025 Timeout counter:
- clears on entry to GET_ADDR or GET_DATA and on every RX_VALID
- increments each cycle while in GET_ADDR or GET_DATA
- reaching TIMEOUT-1: go to IDLE, increment ERR_COUNT, send no response, no REG_WE
REQ-026 RX_VALID in EXEC or SEND SHALL be ignored; it never alters state, registers or ERR_COUNT.
REQ-027 ERR_COUNT SHALL saturate at 255 and never wrap.
REQ-028 A timeout and an RX_VALID in the same cycle: RX_VALID wins and the counter clears.
REQ-029 REG_WE and TX_WE SHALL never be high in the same cycle.

Reset
REQ-030 RST high at a clock edge SHALL, in that edge:
- set state to IDLE
- set TX_DATA, TX_WE, REG_ADDR, REG_WDATA, REG_WE, ERR_COUNT and the timeout counter to 0
- drive BUSY low
REQ-031 Reset mid-operation SHALL abandon the command: no REG_WE and no TX_WE after RST is sampled high.
REQ-032 RST SHALL take priority over every other input in the same cycle.

Verification
REQ-033 Write: bytes 0x57, 0x03, 0xA5 with TX_READY = 1 -> REG_WE for one cycle with REG_ADDR = 0x03 and REG_WDATA = 0xA5; TX_WE two cycles later with TX_DATA = 0x06.
REQ-034 Read: REG_RDATA = 0x3C when REG_ADDR = 0x05; send 0x52, 0x05 -> TX_WE at t+3 with TX_DATA = 0x3C; REG_WE never asserted.
REQ-035 Errors:
- send 0x41 -> TX_DATA = 0x15, ERR_COUNT = 1
- send 0x57, 0x20, 0x11 with NUM_REGS = 16 -> NAK, no REG_WE, ERR_COUNT = 2
REQ-036 Backpressure: hold TX_READY = 0 for 500 cycles during SEND and inject RX_VALID meanwhile -> TX_WE waits until the first cycle TX_READY = 1; the injected bytes are ignored.
REQ-037 Timeout and reset:
- TIMEOUT = 100; send 0x52 then nothing for 100 cycles -> IDLE, no TX_WE, ERR_COUNT = 1
- RST in GET_DATA -> all outputs 0, no REG_WE
REQ-038 Saturation: 300 consecutive bad commands -> ERR_COUNT = 255.
